qspi_cmd_shifter: RTL

QSPI_CMD_SHIFTER -- requirements
Module: qspi_cmd_shifter

---
 rtl/qspi_pkg.sv | 23 ++
 rtl/qspi_lane_shifter.sv | 35 +++
 rtl/qspi_cmd_shifter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/qspi_pkg.sv
// Shared constants and FSM state type for the QSPI command shifter.
package qspi_pkg;

  localparam logic [1:0] LANE_SINGLE = 2'b00;
  localparam logic [1:0] LANE_DUAL   = 2'b01;
  localparam logic [1:0] LANE_QUAD   = 2'b10;

  localparam int CMD_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DONE
  } state_e;

  // The unused lane encoding 2'b11 behaves as quad.
  function automatic logic [1:0] norm_lanes(input logic [1:0] lanes);
    return (lanes == 2'b11) ? LANE_QUAD : lanes;
  endfunction

endpackage

// File: rtl/qspi_lane_shifter.sv
// Loadable MSB-first shift register; the top nibble feeds the IO lanes and
// each shift consumes 1, 2 or 4 bits depending on the lane mode.
module qspi_lane_shifter
  import qspi_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         shift,
  input  logic [1:0]   lanes,
  output logic [3:0]   top
);

  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      sr <= '0;
    end else if (load) begin
      sr <= data;
    end else if (shift) begin
      case (lanes)
        LANE_SINGLE: sr <= sr << 1;
        LANE_DUAL:   sr <= sr << 2;
        default:     sr <= sr << 4;
      endcase
    end
  end

  assign top = sr[W-1 -: 4];

endmodule

// File: rtl/qspi_cmd_shifter.sv
// QSPI command/address/dummy sequencer: SPI mode 0, two clk per bit-cycle,
// chip select held low across all phases of one transaction.
module qspi_cmd_shifter
  import qspi_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [7:0]        command_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              addr_en_i,
  input  logic [1:0]        addr_lanes_i,
  input  logic [3:0]        dummy_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              error_o,
  output logic              cs_no,
  output logic              sck_o,
  output logic [3:0]        io_o,
  output logic [3:0]        io_oe_o,
  output logic [2:0]        dbg_state
);

  localparam int CNT_MAX = (ADDR_W > 15) ? ADDR_W : 15;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SR_W    = CMD_BITS + ADDR_W;

  state_e           state_q, state_d;
  logic             phase_q;
  logic [CNT_W-1:0] cnt_q, cnt_last;
  logic             addr_en_q;
  logic [1:0]       lanes_q;
  logic [3:0]       dummy_q;
  logic             error_q;
  logic             active, accept, bit_end, shift;
  logic [1:0]       shift_lanes;
  logic [3:0]       sr_top;

  assign active    = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DUMMY);
  assign accept    = start_i && (state_q == ST_IDLE) && (command_i != 8'h00);
  assign dbg_state = state_q;

  // Index of the final bit-cycle in the current phase.
  always_comb begin
    cnt_last = '0;
    case (state_q)
      ST_CMD:   cnt_last = CNT_W'(CMD_BITS - 1);
      ST_ADDR: begin
        case (lanes_q)
          LANE_SINGLE: cnt_last = CNT_W'(ADDR_W - 1);
          LANE_DUAL:   cnt_last = CNT_W'(ADDR_W / 2 - 1);
          default:     cnt_last = CNT_W'(ADDR_W / 4 - 1);
        endcase
      end
      ST_DUMMY: cnt_last = CNT_W'(dummy_q) - CNT_W'(1);
      default:  cnt_last = '0;
    endcase
  end

  assign bit_end = active && phase_q && (cnt_q == cnt_last);

  always_ff @(posedge clk) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_CMD;
      ST_CMD: begin
        if (bit_end) begin
          if (addr_en_q)             state_d = ST_ADDR;
          else if (dummy_q != 4'd0)  state_d = ST_DUMMY;
          else                       state_d = ST_DONE;
        end
      end
      ST_ADDR:  if (bit_end) state_d = (dummy_q != 4'd0) ? ST_DUMMY : ST_DONE;
      ST_DUMMY: if (bit_end) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      phase_q   <= 1'b0;
      cnt_q     <= '0;
      addr_en_q <= 1'b0;
      lanes_q   <= LANE_SINGLE;
      dummy_q   <= 4'd0;
      error_q   <= 1'b0;
    end else begin
      error_q <= start_i && (state_q == ST_IDLE) && (command_i == 8'h00);
      if (accept) begin
        addr_en_q <= addr_en_i;
        lanes_q   <= norm_lanes(addr_lanes_i);
        dummy_q   <= dummy_i;
      end
      if (!active) begin
        phase_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        phase_q <= ~phase_q;
        if (phase_q) cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      end
    end
  end

  // Advance the data only after the sck high phase so io_o is stable across it.
  assign shift       = phase_q && ((state_q == ST_CMD) || (state_q == ST_ADDR));
  assign shift_lanes = (state_q == ST_CMD) ? LANE_SINGLE : lanes_q;

  qspi_lane_shifter #(.W(SR_W)) u_shifter (
    .clk    (clk),
    .rst_ni (rst_ni),
    .load   (accept),
    .data   ({command_i, addr_i}),
    .shift  (shift),
    .lanes  (shift_lanes),
    .top    (sr_top)
  );

  always_comb begin
    cs_no   = 1'b1;
    sck_o   = 1'b0;
    io_o    = 4'h0;
    io_oe_o = 4'h0;
    done_o  = 1'b0;
    ready_o = (state_q == ST_IDLE);
    error_o = error_q;
    case (state_q)
      ST_CMD: begin
        cs_no   = 1'b0;
        sck_o   = phase_q;
        io_o    = {3'b000, sr_top[3]};
        io_oe_o = 4'b0001;
      end
      ST_ADDR: begin
        cs_no = 1'b0;
        sck_o = phase_q;
        case (lanes_q)
          LANE_SINGLE: begin io_o = {3'b000, sr_top[3]};   io_oe_o = 4'b0001; end
          LANE_DUAL:   begin io_o = {2'b00, sr_top[3:2]};  io_oe_o = 4'b0011; end
          default:     begin io_o = sr_top;                io_oe_o = 4'b1111; end
        endcase
      end
      ST_DUMMY: begin
        cs_no = 1'b0;
        sck_o = phase_q;
      end
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule
